// File: rtl/fc_engine.sv
// Fully-connected layer engine: streams inputs, row-major weights and optional
// biases, accumulates Q-format dot products, then drains activated, saturated outputs.
module fc_engine #(
    parameter int DW       = 16,
    parameter int FRAC     = 10,
    parameter int MAX_CIN  = 1024,
    parameter int MAX_COUT = 1024,
    parameter int ACC_W    = 2*DW+8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [10:0]   cin,
    input  logic [10:0]   cout,
    input  logic          has_bias,
    input  logic [1:0]    act_type,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din_data,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    output logic          busy,
    output logic          done
);

    localparam int XA = (MAX_CIN  > 1) ? $clog2(MAX_CIN)  : 1;
    localparam int OA = (MAX_COUT > 1) ? $clog2(MAX_COUT) : 1;
    localparam logic [10:0] CIN_LIM  = 11'(MAX_CIN);
    localparam logic [10:0] COUT_LIM = 11'(MAX_COUT);
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD_IN, LOAD_W, LOAD_B, DRAIN, FIN} state_t;

    state_t                  state;
    logic [10:0]             cin_r;
    logic [10:0]             cout_r;
    logic                    has_bias_r;
    logic [1:0]              act_r;
    logic [10:0]             cnt;
    logic [10:0]             row;
    logic signed [ACC_W-1:0] acc;

    logic [DW-1:0]           xbuf [MAX_CIN];
    logic signed [ACC_W-1:0] obuf [MAX_COUT];

    logic                    in_fire;
    logic                    cfg_ok;
    logic                    col_last;
    logic                    row_last;
    logic                    x_we;
    logic                    row_end;
    logic                    b_we;
    logic signed [DW-1:0]    x_cur;
    logic signed [2*DW-1:0]  prod;
    logic signed [2*DW-1:0]  prod_sh;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] ob_rd;

    function automatic logic [DW-1:0] act_sat(input logic signed [ACC_W-1:0] v,
                                              input logic [1:0] t);
        logic signed [ACC_W-1:0] a;
        a = v;
        if (v[ACC_W-1]) begin
            if (t == 2'd1)      a = '0;
            else if (t == 2'd2) a = v >>> 3;
        end
        if (a > SAT_HI)      a = SAT_HI;
        else if (a < SAT_LO) a = SAT_LO;
        return a[DW-1:0];
    endfunction

    always_comb begin
        in_fire  = din_valid && din_ready;
        cfg_ok   = (cin != '0) && (cin <= CIN_LIM) && (cout != '0) && (cout <= COUT_LIM);
        col_last = (cnt == cin_r - 11'd1);
        row_last = (row == cout_r - 11'd1);
        x_we     = in_fire && (state == LOAD_IN);
        row_end  = in_fire && (state == LOAD_W) && col_last;
        b_we     = in_fire && (state == LOAD_B);
        x_cur    = $signed(xbuf[cnt[XA-1:0]]);
        prod     = x_cur * $signed(din_data);
        // arithmetic shift floors toward -inf before widening to the accumulator
        prod_sh  = prod >>> FRAC;
        term     = {{(ACC_W-2*DW){prod_sh[2*DW-1]}}, prod_sh};
        acc_next = ((cnt == '0) ? '0 : acc) + term;
        bias_ext = {{(ACC_W-DW){din_data[DW-1]}}, din_data};
        ob_rd    = obuf[cnt[OA-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (x_we)    xbuf[cnt[XA-1:0]] <= din_data;
            if (row_end) obuf[row[OA-1:0]] <= acc_next;
            if (b_we)    obuf[cnt[OA-1:0]] <= ob_rd + bias_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            din_ready  <= 1'b0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            row        <= '0;
            acc        <= '0;
            cin_r      <= '0;
            cout_r     <= '0;
            has_bias_r <= 1'b0;
            act_r      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cin_r      <= cin;
                        cout_r     <= cout;
                        has_bias_r <= has_bias;
                        act_r      <= act_type;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        row        <= '0;
                        acc        <= '0;
                        if (cfg_ok) begin
                            state     <= LOAD_IN;
                            din_ready <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD_IN: begin
                    if (in_fire) begin
                        if (col_last) begin
                            state <= LOAD_W;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end
                LOAD_W: begin
                    if (in_fire) begin
                        if (col_last) begin
                            acc <= '0;
                            cnt <= '0;
                            if (row_last) begin
                                row <= '0;
                                if (has_bias_r) begin
                                    state <= LOAD_B;
                                end else begin
                                    state     <= DRAIN;
                                    din_ready <= 1'b0;
                                end
                            end else begin
                                row <= row + 11'd1;
                            end
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt + 11'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_fire) begin
                        if (cnt == cout_r - 11'd1) begin
                            state     <= DRAIN;
                            din_ready <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end
                DRAIN: begin
                    // output register refills whenever it is empty or being consumed
                    if (!dout_valid || dout_ready) begin
                        if (cnt < cout_r) begin
                            dout_valid <= 1'b1;
                            dout_data  <= act_sat(ob_rd, act_r);
                            cnt        <= cnt + 11'd1;
                        end else begin
                            dout_valid <= 1'b0;
                            state      <= FIN;
                            done       <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_engine.sv
// Directed self-checking bench for fc_engine with hand-computed expected outputs.
module tb_fc_engine;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [10:0]   cin;
    logic [10:0]   cout;
    logic          has_bias;
    logic [1:0]    act_type;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] din_data;
    logic          dout_valid;
    logic          dout_ready;
    logic [DW-1:0] dout_data;
    logic          busy;
    logic          done;

    int            errors = 0;
    int            checks = 0;
    int            stim[$];
    logic [DW-1:0] got [8];
    int            lat;

    always #5 clk = ~clk;

    fc_engine #(.DW(DW), .FRAC(10), .MAX_CIN(1024), .MAX_COUT(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .cin(cin), .cout(cout),
        .has_bias(has_bias), .act_type(act_type),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int c_in, input int c_out, input bit b, input int act);
        cin      = 11'(c_in);
        cout     = 11'(c_out);
        has_bias = b;
        act_type = 2'(act);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic send(input int n, input bit gappy);
        for (int i = 0; i < n; i++) begin
            int t;
            if (gappy) begin
                din_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            din_valid = 1'b1;
            din_data  = stim[i][DW-1:0];
            t = 0;
            while (!din_ready && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) begin
                chk("din_ready_timeout", t, 0);
                break;
            end
            step();
        end
        din_valid = 1'b0;
    endtask

    task automatic recv(input int n, input int stall_at, output int first_lat);
        int            k = 0;
        int            cyc = 0;
        int            stall_left = 5;
        bit            holding = 1'b0;
        logic [DW-1:0] held = '0;
        first_lat = -1;
        while (k < n && cyc < 200) begin
            if (k == stall_at && stall_left > 0 && dout_valid) begin
                dout_ready = 1'b0;
                stall_left--;
                if (!holding) begin
                    held    = dout_data;
                    holding = 1'b1;
                end else begin
                    chk("stall_data_stable", $signed(dout_data), $signed(held));
                    chk("stall_valid_held", 32'(dout_valid), 1);
                end
            end else begin
                dout_ready = 1'b1;
            end
            if (dout_valid && first_lat < 0) first_lat = cyc;
            if (dout_valid && dout_ready) begin
                got[k] = dout_data;
                k++;
            end
            step();
            cyc++;
        end
        dout_ready = 1'b0;
        if (k < n) chk("recv_timeout", k, n);
    endtask

    task automatic finish_check(input string tag);
        chk({tag, "_done_pulse"}, 32'(done), 1);
        chk({tag, "_no_extra_out"}, 32'(dout_valid), 0);
        step();
        chk({tag, "_done_low"}, 32'(done), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1; start = 1'b0; cin = '0; cout = '0; has_bias = 1'b0; act_type = '0;
        din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_din_ready", 32'(din_ready), 0);
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_dout_data", 32'(dout_data), 0);
        rst = 1'b0;
        step();

        // Dot product, with a stray start during LOAD_IN that must be ignored
        stim = '{1024, 2048, 1024, 512};
        start_job(2, 1, 1'b0, 0);
        chk("load_in_ready", 32'(din_ready), 1);
        chk("load_in_busy", 32'(busy), 1);
        cin = '0; start = 1'b1; step(); start = 1'b0;
        send(stim.size(), 1'b0);
        recv(1, -1, lat);
        chk("dot_out", $signed(got[0]), 2048);
        chk("first_valid_latency_ok", (lat >= 0 && lat <= 3) ? 1 : 0, 1);
        finish_check("dot");

        // Bias with ReLU
        stim = '{1024, -1024, 3072, 0, -1024};
        start_job(1, 2, 1'b1, 1);
        send(stim.size(), 1'b0);
        recv(2, -1, lat);
        chk("relu_out0", $signed(got[0]), 0);
        chk("relu_out1", $signed(got[1]), 2048);
        finish_check("relu");

        // Positive and negative saturation
        stim = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        start_job(4, 1, 1'b0, 0);
        send(stim.size(), 1'b0);
        recv(1, -1, lat);
        chk("sat_pos", $signed(got[0]), 32767);
        finish_check("sat_pos");
        stim = '{32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768};
        start_job(4, 1, 1'b0, 0);
        send(stim.size(), 1'b0);
        recv(1, -1, lat);
        chk("sat_neg", $signed(got[0]), -32768);
        finish_check("sat_neg");

        // Leaky activation
        stim = '{1024, -8192};
        start_job(1, 1, 1'b0, 2);
        send(stim.size(), 1'b0);
        recv(1, -1, lat);
        chk("leaky_out", $signed(got[0]), -1024);
        finish_check("leaky");

        // Shift floors toward -inf; act_type 3 passes through
        stim = '{1, -1};
        start_job(1, 1, 1'b0, 3);
        send(stim.size(), 1'b0);
        recv(1, -1, lat);
        chk("floor_shift", $signed(got[0]), -1);
        finish_check("floor");

        // Invalid sizes go straight to FIN
        start_job(0, 1, 1'b0, 0);
        chk("bad_cin_busy", 32'(busy), 1);
        chk("bad_cin_ready", 32'(din_ready), 0);
        finish_check("bad_cin");
        start_job(1, 1025, 1'b0, 0);
        finish_check("bad_cout");

        // Flow control: input gaps and a 5-cycle output stall
        stim = '{1024, -2048, 1024, 1024, 2048, 512, 512, -512};
        start_job(2, 3, 1'b0, 0);
        send(stim.size(), 1'b1);
        recv(3, 1, lat);
        chk("flow_out0", $signed(got[0]), -1024);
        chk("flow_out1", $signed(got[1]), 1024);
        chk("flow_out2", $signed(got[2]), 1536);
        finish_check("flow");

        // Abort mid LOAD_W, then rerun the dot product
        stim = '{1024, 2048, 1024, 512};
        start_job(2, 1, 1'b0, 0);
        send(3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_din_ready", 32'(din_ready), 0);
        chk("abort_dout_valid", 32'(dout_valid), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done || dout_valid) saw_done = 1'b1;
            step();
        end
        chk("abort_no_done", 32'(saw_done), 0);
        start_job(2, 1, 1'b0, 0);
        send(stim.size(), 1'b0);
        recv(1, -1, lat);
        chk("after_abort_out", $signed(got[0]), 2048);
        finish_check("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_engine.md
FC_ENGINE -- requirements
Module: fc_engine

Interface
REQ-001 SHALL have parameter DW, default 16: signed fixed-point data width for inputs, weights, biases and outputs.
REQ-002 SHALL have parameter FRAC, default 10: fractional bits of the Q format.
REQ-003 SHALL have parameter MAX_CIN, default 1024: input-buffer depth, the maximum cin.
REQ-004 SHALL have parameter MAX_COUT, default 1024: output-buffer depth, the maximum cout.
REQ-005 SHALL have parameter ACC_W, default 2*DW+8: accumulator width.
REQ-006 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  job start pulse, sampled in IDLE only.
- cin  in  11  input count, latched at start.
- cout  in  11  output count, latched at start.
- has_bias  in  1  bias phase enable, latched at start.
- act_type  in  2  activation: 0 none, 1 ReLU, 2 leaky (x>>>3), 3 none; latched at start.
- din_valid  in  1  input stream valid.
- din_ready  out  1  input stream ready.
- din_data  in  DW  input stream word.
- dout_valid  out  1  output valid.
- dout_ready  in  1  output ready.
- dout_data  out  DW  output word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.

Function
REQ-007 SHALL implement the states IDLE, LOAD_IN, LOAD_W, LOAD_B, DRAIN and FIN.
REQ-008 SHALL transfer an input beat only when din_valid and din_ready are both high, and SHALL transfer an output beat only when dout_valid and dout_ready are both high.
REQ-009 SHALL move IDLE->LOAD_IN on start when 1<=cin<=MAX_CIN and 1<=cout<=MAX_COUT; any other cin/cout SHALL move IDLE->FIN with no outputs.
REQ-010 SHALL ignore start outside IDLE.
REQ-011 SHALL, in LOAD_IN, accept exactly cin words into x[0..cin-1], then enter LOAD_W.
REQ-012 SHALL, in LOAD_W, accept exactly cin*cout weights in row-major order: weight k belongs to output k/cin and pairs with input x[k%cin].
REQ-013 SHALL clear the accumulator at the start of each row and add (x*w)>>>FRAC for each weight; the 2*DW product is arithmetically shifted, truncating toward negative infinity, and sign-extended to ACC_W.
REQ-014 SHALL write the accumulator to obuf[row] when the row ends.
REQ-015 SHALL enter LOAD_B after the last weight when has_bias=1, otherwise DRAIN.
REQ-016 SHALL, in LOAD_B, accept exactly cout bias words; bias b[o] is sign-extended and added to obuf[o].
REQ-017 SHALL sustain 1 accepted beat per cycle in LOAD_IN, LOAD_W and LOAD_B with din_valid held high.
REQ-018 SHALL tolerate arbitrary din_valid gaps with no state change during a gap.
REQ-019 SHALL hold din_ready=0 in IDLE, DRAIN and FIN.
REQ-020 SHALL, in DRAIN, emit cout words in order o=0..cout-1: dout_data = sat_DW(act(obuf[o])).
REQ-021 SHALL define act as: ReLU maps negative values to 0; leaky maps negative v to v>>>3.
REQ-022 SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-023 SHALL assert the first dout_valid no more than 3 cycles after the last load beat.
REQ-024 SHALL keep dout_valid and dout_data stable while dout_ready=0.
REQ-025 SHALL sustain 1 output per cycle while dout_ready=1.
REQ-026 SHALL, after the last output handshake, enter FIN, pulse done for exactly 1 cycle, and return to IDLE the next cycle.

Reset
REQ-027 SHALL, on rst, force state IDLE and din_ready=0, dout_valid=0, dout_data=0, busy=0, done=0, and clear all counters and the accumulator; buffer contents need not be cleared.
REQ-028 SHALL treat rst during any state as an abort: no done pulse, no further outputs, and the next job operates correctly.

Verification
REQ-029 SHALL verify dot product: FRAC=10, cin=2, cout=1, x={1024,2048}, w={1024,512}, no bias, act=0 -> dout=2048, then done.
REQ-030 SHALL verify bias with ReLU: cin=1, cout=2, x={1024}, w={-1024,3072}, b={0,-1024}, act=1 -> dout={0,2048}.
REQ-031 SHALL verify saturation: cin=4, all x=32767 and w=32767 -> 32767; then all w=-32768 -> -32768.
REQ-032 SHALL verify leaky activation: cin=1, x=1024, w=-8192, act=2 -> dout=-1024.
REQ-033 SHALL verify flow control: random din_valid gaps and dout_ready low for 5 cycles mid-drain -> identical results, dout_data stable while stalled, no loss or duplication.
REQ-034 SHALL verify abort: rst asserted mid-LOAD_W -> IDLE next cycle, busy=0, no done; a following job with the REQ-029 stimulus -> 2048.
